// File: rtl/rmii_mdio_pkg.sv
// Shared types and frame constants for the Clause 22 MDIO master.
package rmii_mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        TA,
        DATA,
        END
    } mdio_state_e;

    localparam logic [1:0]  MDIO_ST    = 2'b01;
    localparam logic [1:0]  MDIO_OP_WR = 2'b01;
    localparam logic [1:0]  MDIO_OP_RD = 2'b10;
    localparam int unsigned HDR_LEN    = 14;
    localparam int unsigned TA_LEN     = 2;
    localparam int unsigned DATA_LEN   = 16;

endpackage

// File: rtl/rmii_mdio_clkgen.sv
// Free-running MDC divider; tick strobes are registered and coincide with the new MDC level.
module rmii_mdio_clkgen #(
    parameter int unsigned MDC_HALF_DIV = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic mdc_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    logic [7:0] cnt_q;
    logic       mdc_q;
    logic       rise_q;
    logic       fall_q;
    logic       wrap;

    assign wrap = (cnt_q == 8'(MDC_HALF_DIV - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            mdc_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else if (wrap) begin
            cnt_q  <= '0;
            mdc_q  <= ~mdc_q;
            rise_q <= ~mdc_q;
            fall_q <= mdc_q;
        end else begin
            cnt_q  <= cnt_q + 8'd1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end
    end

    assign mdc_o       = mdc_q;
    assign rise_tick_o = rise_q;
    assign fall_tick_o = fall_q;

endmodule

// File: rtl/rmii_mdio_master.sv
// Clause 22 MDIO master: serialises read/write frames on the split MDIO pad.
// Optional MDIO_PREAMBLE_SKIP_EN adds skip_pre to drop the preamble.
module rmii_mdio_master
    import rmii_mdio_pkg::*;
#(
    parameter int unsigned MDC_HALF_DIV = 10,
    parameter int unsigned PRE_LEN      = 32
) (
    input  logic        RMII_REF_CLK,
    input  logic        RMII_RST_N,
    input  logic        start,
    input  logic        op_read,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wdata,
`ifdef MDIO_PREAMBLE_SKIP_EN
    input  logic        skip_pre,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        rd_err,
    output logic        MDC,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    logic rise_tick;
    logic fall_tick;
    logic skip_w;

`ifdef MDIO_PREAMBLE_SKIP_EN
    assign skip_w = skip_pre;
`else
    assign skip_w = 1'b0;
`endif

    rmii_mdio_clkgen #(
        .MDC_HALF_DIV(MDC_HALF_DIV)
    ) u_clkgen (
        .clk_i      (RMII_REF_CLK),
        .rst_ni     (RMII_RST_N),
        .mdc_o      (MDC),
        .rise_tick_o(rise_tick),
        .fall_tick_o(fall_tick)
    );

    logic        mdio_meta_q;
    logic        mdio_sync_q;

    always_ff @(posedge RMII_REF_CLK or negedge RMII_RST_N) begin
        if (!RMII_RST_N) begin
            mdio_meta_q <= 1'b1;
            mdio_sync_q <= 1'b1;
        end else begin
            mdio_meta_q <= mdio_i;
            mdio_sync_q <= mdio_meta_q;
        end
    end

    mdio_state_e state_q;
    logic [7:0]  cnt_q;
    logic [31:0] tx_q;
    logic        op_rd_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] rdata_q;
    logic        rd_err_q;
    logic        mdio_o_q;
    logic        mdio_oe_q;

    // cnt_q counts bits already placed on the line within the current state.
    always_ff @(posedge RMII_REF_CLK or negedge RMII_RST_N) begin
        if (!RMII_RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_q      <= '0;
            op_rd_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            rd_err_q  <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_rd_q  <= op_read;
                        tx_q     <= {MDIO_ST, (op_read ? MDIO_OP_RD : MDIO_OP_WR),
                                     phy_addr, reg_addr, 2'b10, wdata};
                        cnt_q    <= '0;
                        rd_err_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= skip_w ? HDR : PRE;
                    end
                end
                PRE: begin
                    if (fall_tick) begin
                        mdio_oe_q <= 1'b1;
                        mdio_o_q  <= 1'b1;
                        if (cnt_q == 8'(PRE_LEN - 1)) begin
                            cnt_q   <= '0;
                            state_q <= HDR;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                HDR: begin
                    if (fall_tick) begin
                        mdio_oe_q <= 1'b1;
                        mdio_o_q  <= tx_q[31];
                        tx_q      <= {tx_q[30:0], 1'b0};
                        if (cnt_q == 8'(HDR_LEN - 1)) begin
                            cnt_q   <= '0;
                            state_q <= TA;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                TA: begin
                    if (fall_tick) begin
                        mdio_oe_q <= ~op_rd_q;
                        mdio_o_q  <= op_rd_q | tx_q[31];
                        tx_q      <= {tx_q[30:0], 1'b0};
                        if (cnt_q == 8'(TA_LEN - 1)) begin
                            cnt_q   <= '0;
                            state_q <= DATA;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                DATA: begin
                    // The rise seen with cnt_q==0 still belongs to the second TA bit.
                    if (rise_tick && op_rd_q) begin
                        if (cnt_q == 8'd0) begin
                            rd_err_q <= mdio_sync_q;
                        end else begin
                            rdata_q <= {rdata_q[14:0], mdio_sync_q};
                        end
                    end
                    if (fall_tick) begin
                        mdio_oe_q <= ~op_rd_q;
                        mdio_o_q  <= op_rd_q | tx_q[31];
                        tx_q      <= {tx_q[30:0], 1'b0};
                        if (cnt_q == 8'(DATA_LEN - 1)) begin
                            cnt_q   <= '0;
                            state_q <= END;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                END: begin
                    if (rise_tick && op_rd_q) begin
                        rdata_q <= {rdata_q[14:0], mdio_sync_q};
                    end
                    if (fall_tick) begin
                        mdio_oe_q <= 1'b0;
                        mdio_o_q  <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign rd_err  = rd_err_q;
    assign mdio_o  = mdio_o_q;
    assign mdio_oe = mdio_oe_q;

endmodule

// File: tb/tb_rmii_mdio_master.sv
// Directed bench for rmii_mdio_master with a bit-logging PHY model on the MDIO pins.
module tb_rmii_mdio_master;

    logic        RMII_REF_CLK = 1'b0;
    logic        RMII_RST_N   = 1'b0;
    logic        start        = 1'b0;
    logic        op_read      = 1'b0;
    logic [4:0]  phy_addr     = '0;
    logic [4:0]  reg_addr     = '0;
    logic [15:0] wdata        = '0;
    logic        skip_pre     = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        rd_err;
    logic        MDC;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i       = 1'b1;

    int tests = 0;
    int fails = 0;

    rmii_mdio_master #(
        .MDC_HALF_DIV(10),
        .PRE_LEN     (32)
    ) dut (
        .RMII_REF_CLK(RMII_REF_CLK),
        .RMII_RST_N  (RMII_RST_N),
        .start       (start),
        .op_read     (op_read),
        .phy_addr    (phy_addr),
        .reg_addr    (reg_addr),
        .wdata       (wdata),
`ifdef MDIO_PREAMBLE_SKIP_EN
        .skip_pre    (skip_pre),
`endif
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .rd_err      (rd_err),
        .MDC         (MDC),
        .mdio_o      (mdio_o),
        .mdio_oe     (mdio_oe),
        .mdio_i      (mdio_i)
    );

    always #10 RMII_REF_CLK = ~RMII_REF_CLK;

    // PHY model state: per-rise log of line value and master drive enable.
    logic [0:79] bit_log = '0;
    logic [0:79] oe_log  = '0;
    int          n       = 0;
    int          last_n  = 0;
    logic        mdc_prev = 1'b0;
    logic        phy_present = 1'b1;
    logic [4:0]  phy_model_addr = 5'h01;
    logic [15:0] phy_resp = 16'h0000;
    int          phy_pre = 32;

    function automatic logic phy_bit(input int idx);
        int   k;
        logic rd;
        k  = idx - phy_pre;
        rd = phy_present && (k >= 14) && (bit_log[phy_pre +: 4] == 4'b0110) &&
             (bit_log[phy_pre + 4 +: 5] == phy_model_addr);
        if (rd && k == 15) return 1'b0;
        if (rd && k >= 16 && k <= 31) return phy_resp[31 - k];
        return 1'b1;
    endfunction

    always @(negedge RMII_REF_CLK) begin
        if (!RMII_RST_N) begin
            n      = 0;
            mdio_i = 1'b1;
        end else begin
            if (done) begin
                last_n = n;
                n      = 0;
            end
            if (MDC && !mdc_prev && busy && (mdio_oe || n > 0) && n < 80) begin
                bit_log[n] = mdio_oe ? mdio_o : mdio_i;
                oe_log[n]  = mdio_oe;
                n++;
            end
            if (!MDC && mdc_prev) mdio_i = phy_bit(n);
        end
        mdc_prev = MDC;
    end

    task automatic do_start(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                            input logic [15:0] wd, input logic sk);
        @(negedge RMII_REF_CLK);
        start    = 1'b1;
        op_read  = rd;
        phy_addr = pa;
        reg_addr = ra;
        wdata    = wd;
        skip_pre = sk;
        @(negedge RMII_REF_CLK);
        start    = 1'b0;
    endtask

    // Leaves the caller at the negedge of the done cycle (or after the limit).
    task automatic wait_done(input int limit, output int busy_cyc, output logic to);
        busy_cyc = 0;
        to       = 1'b1;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge RMII_REF_CLK);
        end
    endtask

    task automatic test_reset();
        RMII_RST_N = 1'b0;
        repeat (3) @(negedge RMII_REF_CLK);
        tests++; if (MDC !== 1'b0) begin fails++; $display("FAIL reset_mdc got %b want 0", MDC); end
        tests++; if (mdio_o !== 1'b1) begin fails++; $display("FAIL reset_mdio_o got %b want 1", mdio_o); end
        tests++; if (mdio_oe !== 1'b0) begin fails++; $display("FAIL reset_mdio_oe got %b want 0", mdio_oe); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL reset_rdata got %h want 0000", rdata); end
        tests++; if (rd_err !== 1'b0) begin fails++; $display("FAIL reset_rd_err got %b want 0", rd_err); end
        RMII_RST_N = 1'b1;
        repeat (5) @(negedge RMII_REF_CLK);
    endtask

    task automatic test_write();
        int   bc;
        int   extra;
        logic to;
        do_start(1'b0, 5'h01, 5'h00, 16'h8000, 1'b0);
        wait_done(3000, bc, to);
        #1;
        tests++; if (to) begin fails++; $display("FAIL wr_timeout got no done want done"); end
        tests++; if (bit_log[0:63] !== 64'hFFFF_FFFF_5082_8000) begin
            fails++; $display("FAIL wr_bits got %h want ffffffff50828000", bit_log[0:63]); end
        tests++; if (last_n !== 64) begin fails++; $display("FAIL wr_len got %0d want 64", last_n); end
        tests++; if (oe_log[0:63] !== {64{1'b1}}) begin
            fails++; $display("FAIL wr_oe got %h want all ones", oe_log[0:63]); end
        tests++; if (bc < 1281 || bc > 1300) begin
            fails++; $display("FAIL wr_busy_len got %0d want 1281..1300", bc); end
        tests++; if (rd_err !== 1'b0) begin fails++; $display("FAIL wr_rd_err got %b want 0", rd_err); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge RMII_REF_CLK);
            if (done) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL wr_single_done got %0d extra want 0", extra); end
        tests++; if (mdio_oe !== 1'b0) begin fails++; $display("FAIL wr_oe_after got %b want 0", mdio_oe); end
    endtask

    task automatic test_read();
        int   bc;
        logic to;
        phy_present = 1'b1;
        phy_resp    = 16'h0007;
        do_start(1'b1, 5'h01, 5'h02, 16'h0000, 1'b0);
        wait_done(3000, bc, to);
        #1;
        tests++; if (to) begin fails++; $display("FAIL rd_timeout got no done want done"); end
        tests++; if (rdata !== 16'h0007) begin fails++; $display("FAIL rd_data got %h want 0007", rdata); end
        tests++; if (rd_err !== 1'b0) begin fails++; $display("FAIL rd_err got %b want 0", rd_err); end
        tests++; if (bit_log[0:31] !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL rd_pre got %h want ffffffff", bit_log[0:31]); end
        tests++; if (bit_log[32:45] !== 14'b01100000100010) begin
            fails++; $display("FAIL rd_hdr got %b want 01100000100010", bit_log[32:45]); end
        tests++; if (oe_log[0:45] !== {46{1'b1}}) begin
            fails++; $display("FAIL rd_oe_hdr got %h want all ones", oe_log[0:45]); end
        tests++; if (oe_log[46:63] !== 18'b0) begin
            fails++; $display("FAIL rd_oe_release got %b want 0", oe_log[46:63]); end
        tests++; if (bit_log[46:47] !== 2'b10) begin
            fails++; $display("FAIL rd_ta got %b want 10", bit_log[46:47]); end
    endtask

    task automatic test_absent();
        int   bc;
        logic to;
        phy_present = 1'b0;
        do_start(1'b1, 5'h01, 5'h02, 16'h0000, 1'b0);
        wait_done(3000, bc, to);
        #1;
        tests++; if (to) begin fails++; $display("FAIL abs_timeout got no done want done"); end
        tests++; if (rdata !== 16'hFFFF) begin fails++; $display("FAIL abs_rdata got %h want ffff", rdata); end
        tests++; if (rd_err !== 1'b1) begin fails++; $display("FAIL abs_rd_err got %b want 1", rd_err); end
        phy_present = 1'b1;
        do_start(1'b0, 5'h01, 5'h00, 16'h0000, 1'b0);
        wait_done(3000, bc, to);
        #1;
        tests++; if (to || rd_err !== 1'b0) begin
            fails++; $display("FAIL wr_clears_err got %b (timeout %b) want 0", rd_err, to); end
    endtask

    task automatic test_back_to_back();
        int   bc;
        logic to;
        phy_resp = 16'hA5C3;
        do_start(1'b0, 5'h01, 5'h03, 16'h1234, 1'b0);
        repeat (300) @(negedge RMII_REF_CLK);
        do_start(1'b1, 5'h1F, 5'h1F, 16'hFFFF, 1'b0);
        wait_done(3000, bc, to);
        #1;
        tests++; if (to) begin fails++; $display("FAIL b2b_timeout1 got no done want done"); end
        tests++; if (bit_log[0:63] !== 64'hFFFF_FFFF_508E_1234) begin
            fails++; $display("FAIL b2b_ignore got %h want ffffffff508e1234", bit_log[0:63]); end
        start    = 1'b1;
        op_read  = 1'b1;
        phy_addr = 5'h01;
        reg_addr = 5'h02;
        wdata    = 16'h0000;
        @(negedge RMII_REF_CLK);
        start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got busy %b want 1", busy); end
        wait_done(3000, bc, to);
        #1;
        tests++; if (to) begin fails++; $display("FAIL b2b_timeout2 got no done want done"); end
        tests++; if (rdata !== 16'hA5C3) begin fails++; $display("FAIL b2b_rdata got %h want a5c3", rdata); end
        tests++; if (bit_log[32:45] !== 14'b01100000100010) begin
            fails++; $display("FAIL b2b_hdr got %b want 01100000100010", bit_log[32:45]); end
        tests++; if (bc < 1281 || bc > 1300) begin
            fails++; $display("FAIL b2b_busy_len got %0d want 1281..1300", bc); end
    endtask

    task automatic test_reset_mid();
        int   bc;
        int   dcnt;
        logic to;
        do_start(1'b0, 5'h01, 5'h00, 16'hFFFF, 1'b0);
        repeat (1100) @(negedge RMII_REF_CLK);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy_before got %b want 1", busy); end
        RMII_RST_N = 1'b0;
        #1;
        tests++; if (mdio_oe !== 1'b0) begin fails++; $display("FAIL rst_mid_oe got %b want 0", mdio_oe); end
        tests++; if (MDC !== 1'b0) begin fails++; $display("FAIL rst_mid_mdc got %b want 0", MDC); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge RMII_REF_CLK);
            if (done) dcnt++;
        end
        RMII_RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge RMII_REF_CLK);
            if (done) dcnt++;
        end
        tests++; if (dcnt !== 0) begin fails++; $display("FAIL rst_mid_done got %0d want 0", dcnt); end
        tests++; if (MDC !== 1'b0) begin fails++; $display("FAIL rst_mdc_restart got %b want 0", MDC); end
        phy_resp = 16'h1234;
        do_start(1'b1, 5'h01, 5'h02, 16'h0000, 1'b0);
        wait_done(3000, bc, to);
        #1;
        tests++; if (to || rdata !== 16'h1234) begin
            fails++; $display("FAIL rst_read got %h (timeout %b) want 1234", rdata, to); end
        tests++; if (rd_err !== 1'b0) begin fails++; $display("FAIL rst_read_err got %b want 0", rd_err); end
    endtask

`ifdef MDIO_PREAMBLE_SKIP_EN
    task automatic test_skip();
        int   bc;
        logic to;
        phy_pre  = 0;
        phy_resp = 16'h3C5A;
        do_start(1'b1, 5'h01, 5'h02, 16'h0000, 1'b1);
        wait_done(2000, bc, to);
        #1;
        tests++; if (to) begin fails++; $display("FAIL skip_timeout got no done want done"); end
        tests++; if (bit_log[0:13] !== 14'b01100000100010) begin
            fails++; $display("FAIL skip_hdr got %b want 01100000100010", bit_log[0:13]); end
        tests++; if (oe_log[14:31] !== 18'b0) begin
            fails++; $display("FAIL skip_oe got %b want 0", oe_log[14:31]); end
        tests++; if (bc < 641 || bc > 660) begin
            fails++; $display("FAIL skip_busy_len got %0d want 641..660", bc); end
        tests++; if (rdata !== 16'h3C5A) begin fails++; $display("FAIL skip_rdata got %h want 3c5a", rdata); end
        phy_pre  = 32;
        skip_pre = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_absent();
        test_back_to_back();
        test_reset_mid();
`ifdef MDIO_PREAMBLE_SKIP_EN
        test_skip();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rmii_mdio_master.md
Name: rmii_mdio_master

Overview:
- MDIO management master (IEEE 802.3 Clause 22) for the RMII PHY.
- Generates MDC from the 50 MHz RMII_REF_CLK and serialises read/write frames on MDIO.
- Sits between the on-chip configuration logic (register file or init sequencer) and the PHY management pins.
- The tri-state MDIO pad is split into mdio_o / mdio_oe / mdio_i and resolved in the top-level I/O buffer.

Parameters:
- MDC_HALF_DIV, 10, RMII_REF_CLK cycles per MDC half-period (50 MHz / 20 = 2.5 MHz); legal range 2..255.
- PRE_LEN, 32, number of preamble '1' bits sent before ST.

Ports:
- RMII_REF_CLK  in  1  50 MHz clock; only clock of the block.
- RMII_RST_N  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request strobe; accepted only while busy=0.
- op_read  in  1  1 = read frame (OP=10), 0 = write frame (OP=01); sampled with start.
- phy_addr  in  5  PHYAD; sampled with start.
- reg_addr  in  5  REGAD; sampled with start.
- wdata  in  16  write data; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at frame completion.
- rdata  out  16  read data; valid from done until the next accepted start.
- rd_err  out  1  valid with done; 1 when the PHY did not drive TA bit 2 low on a read.
- MDC  out  1  management clock, free-running.
- mdio_o  out  1  MDIO output value.
- mdio_oe  out  1  MDIO output enable; 1 = master drives.
- mdio_i  in  1  MDIO pad input.

Behaviour:
- Reset values: MDC=0, mdio_o=1, mdio_oe=0, busy=0, done=0, rdata=0, rd_err=0, FSM=IDLE, all counters cleared.
- Reset mid-frame aborts immediately with no done pulse. After release, MDC resumes from 0.

MDC generation:
- Counter runs 0..MDC_HALF_DIV-1 and toggles MDC on wrap.
- fall_tick and rise_tick are single-cycle strobes in the cycle MDC toggles 1->0 and 0->1.

Frame timing:
- Master updates mdio_o / mdio_oe registered on fall_tick, so MDIO changes one clk after MDC falls.
- Master samples the mdio_i synchroniser output on rise_tick.
- mdio_i passes through a 2-flop synchroniser before use.

FSM states:
- IDLE: mdio_oe=0. A start with busy=0 latches the request and sets busy on the next cycle; the first bit goes out at the next fall_tick.
- PRE: drives PRE_LEN ones.
- HDR: drives 14 bits MSB-first: ST=01, OP, PHYAD[4:0], REGAD[4:0].
- TA, write: drives 1 then 0.
- TA, read: mdio_oe=0 for both bits. The rise_tick sample of the second bit is compared to 0; a mismatch sets the rd_err latch.
- DATA, write: drives wdata[15:0] MSB-first.
- DATA, read: mdio_oe=0; shifts in 16 bits on rise_tick, MSB first.
- END: at the fall_tick that closes the last data bit: mdio_oe=0, done=1 for one cycle, busy=0 in the same cycle, rdata/rd_err updated, return to IDLE.

Frame length and back-to-back:
- Frame length is PRE_LEN+32 MDC periods: 64 periods = 1280 clk at default, plus up to 20 clk start alignment.
- A start in the done cycle is accepted (busy is already 0). The next frame begins at the following fall_tick, giving at least one idle MDC period between frames.
- start while busy=1 is ignored; no queueing, no flag.
- rd_err is 0 for writes.

Optional Feature:
- Macro MDIO_PREAMBLE_SKIP_EN.
- Defined: adds input port skip_pre (1 bit, sampled with start). skip_pre=1 omits PRE and goes straight to HDR, giving a 32-period frame. skip_pre=0 behaves as normal.
- Undefined: port absent; the preamble is always sent.

Decomposition:
- Package rmii_mdio_pkg:
  - state enum {IDLE, PRE, HDR, TA, DATA, END};
  - constants MDIO_ST=2'b01, MDIO_OP_WR=2'b01, MDIO_OP_RD=2'b10, HDR_LEN=14, TA_LEN=2, DATA_LEN=16.
- Sub-module rmii_mdio_clkgen: MDC divider producing MDC, rise_tick, fall_tick; parameter MDC_HALF_DIV.

Test Plan:
- Write, phy=5'h01, reg=5'h00, wdata=16'h8000:
  - PHY model decodes 32 ones, 01, 01, 00001, 00000, TA 10, 0x8000;
  - done exactly one pulse; busy high about 1280 clk; mdio_oe=0 after.
- Read, phy=5'h01, reg=5'h02, PHY model returns TA-low and 16'h0007:
  - rdata=16'h0007, rd_err=0;
  - mdio_oe=0 from TA bit 1 to frame end.
- Read with PHY absent (pull-up, mdio_i=1):
  - rdata=16'hFFFF, rd_err=1.
- start pulsed again mid-frame with different addr:
  - ignored; frame bits unchanged; a single done.
  - Start in the done cycle is accepted; a second frame follows.
- Assert RMII_RST_N low during DATA of a write:
  - immediately mdio_oe=0, MDC=0, busy=0, no done.
  - After release, a fresh read completes correctly.
- With MDIO_PREAMBLE_SKIP_EN, skip_pre=1 read:
  - frame starts directly with 01, 10;
  - done about 640 clk after start, correct rdata.
